// File: rtl/hs_sync_detector.sv
// HS start-of-transmission sync detector: hunts the serial HS bit stream for the
// sync byte and enables the downstream deserializer aligned to the first payload bit.
module hs_sync_detector #(
    parameter logic [7:0] SYNC_WORD  = 8'hB8,
    parameter int         HUNT_LIMIT = 32,
    parameter bit         TOL_1BIT   = 1'b1
) (
    input  logic RxDDRClkHS,
    input  logic RST,
    input  logic HS_RX_DATA,
    input  logic HS_RX_ACTIVE,
    output logic Enable,
    output logic RX_SYNC_HS,
    output logic ERR_SOT_HS,
    output logic ERR_SOT_SYNC_HS
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        RECEIVE = 2'd2,
        FAIL    = 2'd3
    } state_t;

    localparam logic [7:0] LIMIT_LAST = 8'(HUNT_LIMIT - 1);

    // True when the two bytes differ in exactly one bit position.
    function automatic logic is_dist1(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a ^ b;
        return (d != 8'd0) && ((d & (d - 8'd1)) == 8'd0);
    endfunction

    state_t     state_r, state_s;
    logic [7:0] shreg_r, shreg_s;
    logic [7:0] cnt_r, cnt_s;
    logic       enable_r, enable_s;
    logic       sync_r, sync_s;
    logic       err_sot_r, err_sot_s;
    logic       err_sync_r, err_sync_s;
    logic [7:0] window_s;
    logic       armed_s;

    assign window_s = {HS_RX_DATA, shreg_r[7:1]};
    assign armed_s  = (cnt_r >= 8'd7);

    // State, shift register, counter and registered outputs.
    always_ff @(posedge RxDDRClkHS or negedge RST) begin
        if (!RST) begin
            state_r    <= IDLE;
            shreg_r    <= 8'd0;
            cnt_r      <= 8'd0;
            enable_r   <= 1'b0;
            sync_r     <= 1'b0;
            err_sot_r  <= 1'b0;
            err_sync_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            cnt_r      <= cnt_s;
            enable_r   <= enable_s;
            sync_r     <= sync_s;
            err_sot_r  <= err_sot_s;
            err_sync_r <= err_sync_s;
        end
    end

    // Next-state and next-output logic; line inactivity always wins in HUNT.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        cnt_s      = cnt_r;
        enable_s   = 1'b0;
        sync_s     = 1'b0;
        err_sot_s  = 1'b0;
        err_sync_s = 1'b0;
        case (state_r)
            IDLE: begin
                shreg_s = 8'd0;
                cnt_s   = 8'd0;
                if (HS_RX_ACTIVE) begin
                    state_s = HUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            HUNT: begin
                if (!HS_RX_ACTIVE) begin
                    state_s = IDLE;
                    shreg_s = 8'd0;
                    cnt_s   = 8'd0;
                end else begin
                    shreg_s = window_s;
                    if (cnt_r == 8'hFF) begin
                        cnt_s = cnt_r;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                    if (armed_s && (window_s == SYNC_WORD)) begin
                        state_s  = RECEIVE;
                        enable_s = 1'b1;
                        sync_s   = 1'b1;
                    end else if (armed_s && TOL_1BIT && is_dist1(window_s, SYNC_WORD)) begin
                        state_s   = RECEIVE;
                        enable_s  = 1'b1;
                        sync_s    = 1'b1;
                        err_sot_s = 1'b1;
                    end else if (cnt_r == LIMIT_LAST) begin
                        state_s    = FAIL;
                        err_sync_s = 1'b1;
                    end else begin
                        state_s = HUNT;
                    end
                end
            end
            RECEIVE: begin
                if (HS_RX_ACTIVE) begin
                    enable_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            FAIL: begin
                if (HS_RX_ACTIVE) begin
                    state_s = FAIL;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                shreg_s = 8'd0;
                cnt_s   = 8'd0;
            end
        endcase
    end

    assign Enable          = enable_r;
    assign RX_SYNC_HS      = sync_r;
    assign ERR_SOT_HS      = err_sot_r;
    assign ERR_SOT_SYNC_HS = err_sync_r;

endmodule

// File: tb/tb_hs_sync_detector.sv
// Directed bench for hs_sync_detector: one instance tolerates 1-bit errors, one does not.
module tb_hs_sync_detector;

    logic clk = 1'b0;
    logic RST = 1'b0;
    logic HS_RX_DATA = 1'b0;
    logic HS_RX_ACTIVE = 1'b0;
    logic en1, sy1, es1, ef1;
    logic en0, sy0, es0, ef0;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    hs_sync_detector #(.SYNC_WORD(8'hB8), .HUNT_LIMIT(32), .TOL_1BIT(1'b1)) u_dut (
        .RxDDRClkHS(clk), .RST(RST), .HS_RX_DATA(HS_RX_DATA), .HS_RX_ACTIVE(HS_RX_ACTIVE),
        .Enable(en1), .RX_SYNC_HS(sy1), .ERR_SOT_HS(es1), .ERR_SOT_SYNC_HS(ef1)
    );

    hs_sync_detector #(.SYNC_WORD(8'hB8), .HUNT_LIMIT(32), .TOL_1BIT(1'b0)) u_dut0 (
        .RxDDRClkHS(clk), .RST(RST), .HS_RX_DATA(HS_RX_DATA), .HS_RX_ACTIVE(HS_RX_ACTIVE),
        .Enable(en0), .RX_SYNC_HS(sy0), .ERR_SOT_HS(es0), .ERR_SOT_SYNC_HS(ef0)
    );

    // Observed {Enable, RX_SYNC_HS, ERR_SOT_HS, ERR_SOT_SYNC_HS}
    function automatic logic [3:0] obs1();
        return {en1, sy1, es1, ef1};
    endfunction

    function automatic logic [3:0] obs0();
        return {en0, sy0, es0, ef0};
    endfunction

    task automatic step(input logic act, input logic dat);
        @(negedge clk);
        HS_RX_ACTIVE = act;
        HS_RX_DATA   = dat;
        @(posedge clk);
        #1;
    endtask

    // Activation edge, 4 zeros, then the first 7 bits of sbyte (LSB first); no output expected.
    task automatic prime(input logic [7:0] sbyte);
        logic [7:0] b;
        b = sbyte;
        for (int i = 0; i < 12; i++) begin
            if (i < 5) step(1'b1, 1'b0);
            else       step(1'b1, b[i-5]);
            chk_cnt++;
            if (obs1() !== 4'b0000 || obs0() !== 4'b0000) begin
                $display("FAIL prime_step%0d: got %b/%b want 0000/0000", i, obs1(), obs0());
            end else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        HS_RX_ACTIVE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (obs1() !== 4'b0000 || obs0() !== 4'b0000) begin
            $display("FAIL reset_state: got %b/%b want 0000/0000", obs1(), obs0());
        end else pass_cnt++;
        @(negedge clk);
        RST = 1'b1;
    endtask

    task automatic test_sync_exact();
        logic [7:0] sw;
        sw = 8'hB8;
        prime(8'hB8);
        step(1'b1, 1'b1);
        chk_cnt++;
        if (obs1() !== 4'b1100 || obs0() !== 4'b1100) begin
            $display("FAIL exact_sync: got %b/%b want 1100/1100", obs1(), obs0());
        end else pass_cnt++;
        // A second sync byte inside RECEIVE must not retrigger anything
        for (int i = 0; i < 8; i++) begin
            step(1'b1, sw[i]);
            chk_cnt++;
            if (obs1() !== 4'b1000 || obs0() !== 4'b1000) begin
                $display("FAIL exact_receive%0d: got %b/%b want 1000/1000", i, obs1(), obs0());
            end else pass_cnt++;
        end
        step(1'b0, 1'b0);
        chk_cnt++;
        if (obs1() !== 4'b0000 || obs0() !== 4'b0000) begin
            $display("FAIL exact_end: got %b/%b want 0000/0000", obs1(), obs0());
        end else pass_cnt++;
    endtask

    task automatic test_sync_1bit();
        prime(8'hBC);
        step(1'b1, 1'b1);
        chk_cnt++;
        if (obs1() !== 4'b1110 || obs0() !== 4'b0000) begin
            $display("FAIL tol_sync: got %b/%b want 1110/0000", obs1(), obs0());
        end else pass_cnt++;
        // Strict instance keeps hunting until the limit at HUNT edge 32
        for (int e = 13; e <= 32; e++) begin
            step(1'b1, 1'b0);
            chk_cnt++;
            if (e < 32 && (obs1() !== 4'b1000 || obs0() !== 4'b0000)) begin
                $display("FAIL tol_hunt%0d: got %b/%b want 1000/0000", e, obs1(), obs0());
            end else if (e == 32 && (obs1() !== 4'b1000 || obs0() !== 4'b0001)) begin
                $display("FAIL tol_limit: got %b/%b want 1000/0001", obs1(), obs0());
            end else pass_cnt++;
        end
        step(1'b0, 1'b0);
        chk_cnt++;
        if (obs1() !== 4'b0000 || obs0() !== 4'b0000) begin
            $display("FAIL tol_end: got %b/%b want 0000/0000", obs1(), obs0());
        end else pass_cnt++;
    endtask

    task automatic test_hunt_limit();
        logic [7:0] sw;
        sw = 8'hB8;
        step(1'b1, 1'b0);
        for (int e = 1; e <= 33; e++) begin
            step(1'b1, 1'b0);
            chk_cnt++;
            if (e == 32 && (obs1() !== 4'b0001 || obs0() !== 4'b0001)) begin
                $display("FAIL limit_pulse: got %b/%b want 0001/0001", obs1(), obs0());
            end else if (e != 32 && (obs1() !== 4'b0000 || obs0() !== 4'b0000)) begin
                $display("FAIL limit_edge%0d: got %b/%b want 0000/0000", e, obs1(), obs0());
            end else pass_cnt++;
        end
        // Sync byte while in FAIL must be ignored
        for (int i = 0; i < 8; i++) begin
            step(1'b1, sw[i]);
            chk_cnt++;
            if (obs1() !== 4'b0000 || obs0() !== 4'b0000) begin
                $display("FAIL limit_hold%0d: got %b/%b want 0000/0000", i, obs1(), obs0());
            end else pass_cnt++;
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_drop_on_last();
        prime(8'hB8);
        step(1'b0, 1'b1);
        chk_cnt++;
        if (obs1() !== 4'b0000 || obs0() !== 4'b0000) begin
            $display("FAIL drop_last: got %b/%b want 0000/0000", obs1(), obs0());
        end else pass_cnt++;
        step(1'b0, 1'b0);
        chk_cnt++;
        if (obs1() !== 4'b0000 || obs0() !== 4'b0000) begin
            $display("FAIL drop_idle: got %b/%b want 0000/0000", obs1(), obs0());
        end else pass_cnt++;
    endtask

    task automatic test_rst_mid_receive();
        prime(8'hB8);
        step(1'b1, 1'b1);
        chk_cnt++;
        if (obs1() !== 4'b1100) begin
            $display("FAIL rst_presync: got %b want 1100", obs1());
        end else pass_cnt++;
        for (int i = 0; i < 20; i++) step(1'b1, i[0]);
        chk_cnt++;
        if (obs1() !== 4'b1000 || obs0() !== 4'b1000) begin
            $display("FAIL rst_receive20: got %b/%b want 1000/1000", obs1(), obs0());
        end else pass_cnt++;
        @(negedge clk);
        RST = 1'b0;
        #1;
        chk_cnt++;
        if (obs1() !== 4'b0000 || obs0() !== 4'b0000) begin
            $display("FAIL rst_async: got %b/%b want 0000/0000", obs1(), obs0());
        end else pass_cnt++;
        @(negedge clk);
        RST = 1'b1;
        prime(8'hB8);
        step(1'b1, 1'b1);
        chk_cnt++;
        if (obs1() !== 4'b1100 || obs0() !== 4'b1100) begin
            $display("FAIL rst_resync: got %b/%b want 1100/1100", obs1(), obs0());
        end else pass_cnt++;
        step(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        for (int burst = 0; burst < 2; burst++) begin
            prime(8'hB8);
            step(1'b1, 1'b1);
            if (sy1 === 1'b1) pulses++;
            step(1'b1, 1'b0);
            chk_cnt++;
            if (obs1() !== 4'b1000) begin
                $display("FAIL b2b_payload%0d: got %b want 1000", burst, obs1());
            end else pass_cnt++;
            step(1'b0, 1'b0);
            chk_cnt++;
            if (obs1() !== 4'b0000) begin
                $display("FAIL b2b_gap%0d: got %b want 0000", burst, obs1());
            end else pass_cnt++;
        end
        chk_cnt++;
        if (pulses !== 2) begin
            $display("FAIL b2b_pulses: got %0d want 2", pulses);
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sync_exact();
        test_sync_1bit();
        test_hunt_limit();
        test_drop_on_last();
        test_rst_mid_receive();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/hs_sync_detector.md
HS_SYNC_DETECTOR -- requirements
Module: hs_sync_detector

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hB8: the HS sync byte, transmitted LSB first.
REQ-002 SHALL have parameter HUNT_LIMIT, default 32, legal range 8..255: the maximum number of bits examined in HUNT.
REQ-003 SHALL have parameter TOL_1BIT, default 1: when 1, a sync byte with a single-bit error is accepted.
REQ-004 SHALL have port RxDDRClkHS, input, 1 bit: the only clock; one HS bit per rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port HS_RX_DATA, input, 1 bit: serial HS line bit, synchronous to RxDDRClkHS.
REQ-007 SHALL have port HS_RX_ACTIVE, input, 1 bit: the line is in HS mode; synchronous level input.
REQ-008 SHALL have port Enable, output, 1 bit, registered: drives the downstream deserializer enable.
REQ-009 SHALL have port RX_SYNC_HS, output, 1 bit: one-cycle pulse when sync is acquired.
REQ-010 SHALL have port ERR_SOT_HS, output, 1 bit: one-cycle pulse when sync is acquired with a 1-bit error.
REQ-011 SHALL have port ERR_SOT_SYNC_HS, output, 1 bit: one-cycle pulse when no sync is found within HUNT_LIMIT bits.

Function
REQ-012 SHALL implement a four-state FSM with states IDLE, HUNT, RECEIVE and FAIL.
REQ-013 SHALL use an 8-bit shift register with the newest bit at the MSB; the compare window SHALL be {HS_RX_DATA, shreg[7:1]}.
REQ-014 SHALL, in IDLE, clear shreg and the bit counter and hold Enable at 0; HS_RX_ACTIVE=1 SHALL move the FSM to HUNT on the next edge.
REQ-015 SHALL, in HUNT, shift HS_RX_DATA into shreg and increment the 8-bit bit counter (saturating) on every edge.
REQ-016 SHALL test the window against SYNC_WORD only when the bit counter is >= 7, so that 8 real bits are present.
REQ-017 SHALL, on an exact match in HUNT: set Enable to 1, pulse RX_SYNC_HS, and move to RECEIVE on the same edge.
REQ-018 SHALL, when there is no exact match, TOL_1BIT=1 and the window is at Hamming distance 1 from SYNC_WORD, act as REQ-017 and also pulse ERR_SOT_HS; an exact match SHALL take priority.
REQ-019 SHALL, when the bit counter equals HUNT_LIMIT-1 with no match: pulse ERR_SOT_SYNC_HS, keep Enable at 0, and move to FAIL.
REQ-020 SHALL give Enable a latency of one edge: last sync bit at cycle t gives Enable=1 at cycle t+1, aligned with the first payload bit on HS_RX_DATA.
REQ-021 SHALL, in RECEIVE, hold Enable at 1 while HS_RX_ACTIVE=1; HS_RX_ACTIVE=0 SHALL move the FSM to IDLE with Enable=0 on that edge.
REQ-022 SHALL, in FAIL, hold Enable at 0 until HS_RX_ACTIVE=0, then move to IDLE; no further pulses SHALL occur in FAIL.
REQ-023 SHALL, when HS_RX_ACTIVE=0 in HUNT, move to IDLE with no error pulse; this SHALL take priority over a same-cycle match or limit hit (no pulse, Enable stays 0).
REQ-024 SHALL keep all pulses exactly one cycle wide and mutually exclusive, except the RX_SYNC_HS+ERR_SOT_HS pair.
REQ-025 SHALL NOT re-hunt inside RECEIVE; a new burst SHALL require an HS_RX_ACTIVE low period (at least 1 cycle, through IDLE).

Reset
REQ-026 SHALL, on RST low (asynchronous, any state), force: FSM=IDLE, shreg=0, counter=0, Enable=0, RX_SYNC_HS=0, ERR_SOT_HS=0, ERR_SOT_SYNC_HS=0.
REQ-027 SHALL, after RST is released mid-burst with HS_RX_ACTIVE=1, enter HUNT on the next edge and start a fresh hunt.

Verification
REQ-028 SHALL be verified by this scenario: HS_RX_ACTIVE rises at cycle 0; bits from cycle 1 are 0,0,0,0 then 0,0,0,1,1,1,0,1 -> match at cycle 12, Enable=1 and RX_SYNC_HS=1 at cycle 13, RX_SYNC_HS=0 at cycle 14, no error pulses.
REQ-029 SHALL be verified by this scenario: as REQ-028 with the 3rd sync bit flipped (window 8'hBC), TOL_1BIT=1 -> RX_SYNC_HS=1 and ERR_SOT_HS=1 at cycle 13; with TOL_1BIT=0 -> no sync, continue hunting.
REQ-030 SHALL be verified by this scenario: all-zero bits for 32 HUNT cycles (cycles 1..32) -> ERR_SOT_SYNC_HS=1 at cycle 33, Enable=0 throughout, FSM stays in FAIL until HS_RX_ACTIVE=0.
REQ-031 SHALL be verified by this scenario: HS_RX_ACTIVE drops in the same cycle as the last sync bit -> Enable=0, RX_SYNC_HS=0, FSM=IDLE.
REQ-032 SHALL be verified by this scenario: RST pulsed low at cycle 20 of RECEIVE -> Enable=0 immediately (asynchronous); after release with HS_RX_ACTIVE=1 -> HUNT, and resync occurs on the next valid sync byte.
REQ-033 SHALL be verified by this scenario: two bursts separated by 1 cycle of HS_RX_ACTIVE=0 -> two RX_SYNC_HS pulses, and Enable low for at least 1 cycle between bursts.
